// File: rtl/imm_gen_pipe_if.sv
// Stream bundle for the immediate generator: instruction in, decoded immediate out,
// plus the illegal-opcode counter controls.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic             ill_clr;
    logic [CNT_W-1:0] ill_count;

    modport master (
        output in_valid, in_inst, in_tag, out_ready, ill_clr,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, ill_count
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready, ill_clr,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, ill_count
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage RV immediate generator: one-cycle latency, full throughput, skid-buffered
// valid/ready with a registered in_ready, tag pass-through and a saturating illegal counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } res_t;

    // Occupancy of the main (M) and skid (K) registers; K is only ever full when M is.
    typedef enum logic [1:0] {
        S_EMPTY,
        S_MAIN,
        S_BOTH
    } state_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0111011:                         decode_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011,
            7'b1110011, 7'b0001111:                         decode_fmt = FMT_I;
            7'b0100011:                                     decode_fmt = FMT_S;
            7'b1100011:                                     decode_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         decode_fmt = FMT_U;
            7'b1101111:                                     decode_fmt = FMT_J;
            default:                                        decode_fmt = FMT_ILL;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] build_imm(input logic [31:0] inst, input fmt_e fmt);
        case (fmt)
            FMT_I:   build_imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            FMT_S:   build_imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
            FMT_B:   build_imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   build_imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            FMT_J:   build_imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: build_imm = '0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    res_t             m_q, k_q, dec;
    logic             in_fire, out_fire;
    logic             load_m_in, load_m_k, load_k;
    logic [CNT_W-1:0] ill_cnt_q;

    always_comb begin
        dec.fmt     = decode_fmt(bus.in_inst[6:0]);
        dec.imm     = build_imm(bus.in_inst, dec.fmt);
        dec.illegal = (dec.fmt == FMT_ILL);
        dec.tag     = bus.in_tag;
    end

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // NOTE: every output of this block gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_k  = 1'b0;
        load_k    = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    load_m_in = 1'b1;
                    state_d   = S_MAIN;
                end
            end
            S_MAIN: begin
                if (in_fire && out_fire) begin
                    load_m_in = 1'b1;
                end else if (in_fire) begin
                    load_k  = 1'b1;
                    state_d = S_BOTH;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_BOTH: begin
                // in_ready is low here, so only the drain of K into M can happen.
                if (out_fire) begin
                    load_m_k = 1'b1;
                    state_d  = S_MAIN;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_BOTH);
            out_valid_q <= (state_d != S_EMPTY);
            if (load_m_in) begin
                m_q <= dec;
            end else if (load_m_k) begin
                m_q <= k_q;
            end
        end
    end

    // NOTE: the skid payload has no reset; it is only read when its valid state says
    // so, and resetting the state alone discards it.
    always_ff @(posedge clk) begin
        if (load_k) begin
            k_q <= dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_cnt_q <= '0;
        end else if (bus.ill_clr) begin
            ill_cnt_q <= '0;
        end else if (in_fire && dec.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_q <= ill_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = m_q.imm;
    assign bus.out_fmt     = m_q.fmt;
    assign bus.out_illegal = m_q.illegal;
    assign bus.out_tag     = m_q.tag;
    assign bus.ill_count   = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit instance for decode, handshake and reset,
// and a 64-bit instance with a 4-bit counter for sign extension and saturation.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8), .CNT_W(16)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8), .CNT_W(4))  b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(4))  dut64 (.clk(clk), .rst(rst), .bus(b64));

    logic [31:0] bp_inst [4];
    logic [63:0] bp_imm  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction at a negedge and checks its result one edge later.
    task automatic xfer(input bit w64, input logic [31:0] inst, input logic [7:0] tag,
                        input logic [63:0] exp_imm, input logic [2:0] exp_fmt, input string name);
        logic        rdy, vld, ill;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [7:0]  otag;
        if (w64) begin
            b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_tag = tag; b64.out_ready = 1'b1;
            rdy = b64.in_ready;
        end else begin
            b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_tag = tag; b32.out_ready = 1'b1;
            rdy = b32.in_ready;
        end
        check({name, ".in_ready"}, 64'(rdy), 64'd1);
        @(negedge clk);
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
        if (w64) begin
            vld = b64.out_valid; imm = b64.out_imm; fmt = b64.out_fmt;
            ill = b64.out_illegal; otag = b64.out_tag;
        end else begin
            vld = b32.out_valid; imm = 64'(b32.out_imm); fmt = b32.out_fmt;
            ill = b32.out_illegal; otag = b32.out_tag;
        end
        check({name, ".valid"}, 64'(vld), 64'd1);
        check({name, ".imm"}, imm, exp_imm);
        check({name, ".fmt"}, 64'(fmt), 64'(exp_fmt));
        check({name, ".illegal"}, 64'(ill), 64'(exp_fmt == 3'd7));
        check({name, ".tag"}, 64'(otag), 64'(tag));
    endtask

    task automatic idle();
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int got;
        bit accept;

        b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_tag = '0; b32.out_ready = 1'b0; b32.ill_clr = 1'b0;
        b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_tag = '0; b64.out_ready = 1'b0; b64.ill_clr = 1'b0;
        bp_inst[0] = 32'hFFF00093; bp_imm[0] = 64'hFFFF_FFFF;
        bp_inst[1] = 32'h123450B7; bp_imm[1] = 64'h1234_5000;
        bp_inst[2] = 32'h7E102FA3; bp_imm[2] = 64'h0000_07FF;
        bp_inst[3] = 32'hFE000EE3; bp_imm[3] = 64'hFFFF_FFFC;

        repeat (2) @(negedge clk);
        check("rst.out_valid", 64'(b32.out_valid), 64'd0);
        check("rst.in_ready", 64'(b32.in_ready), 64'd1);
        check("rst.out_imm", 64'(b32.out_imm), 64'd0);
        check("rst.out_fmt", 64'(b32.out_fmt), 64'd0);
        check("rst.out_illegal", 64'(b32.out_illegal), 64'd0);
        check("rst.out_tag", 64'(b32.out_tag), 64'd0);
        check("rst.ill_count", 64'(b32.ill_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Decode of every format, back to back at full rate.
        xfer(1'b0, 32'h001000EF, 8'h11, 64'h0000_0800, 3'd5, "jal_p2048");
        xfer(1'b0, 32'hFE000EE3, 8'h12, 64'hFFFF_FFFC, 3'd3, "beq_m4");
        xfer(1'b0, 32'hFFF00093, 8'h13, 64'hFFFF_FFFF, 3'd1, "addi_m1");
        xfer(1'b0, 32'h123450B7, 8'h14, 64'h1234_5000, 3'd4, "lui");
        xfer(1'b0, 32'h7E102FA3, 8'h15, 64'h0000_07FF, 3'd2, "sw_7ff");
        xfer(1'b0, 32'h003100B3, 8'h16, 64'h0000_0000, 3'd0, "add");
        xfer(1'b0, 32'hFFDFF06F, 8'h17, 64'hFFFF_FFFC, 3'd5, "jal_m4");

        // Illegal opcodes and counter clear priority.
        xfer(1'b0, 32'h0000007F, 8'h5A, 64'h0, 3'd7, "ill_7f");
        check("ill.count1", 64'(b32.ill_count), 64'd1);
        xfer(1'b0, 32'h00000057, 8'h5B, 64'h0, 3'd7, "ill_57");
        check("ill.count2", 64'(b32.ill_count), 64'd2);
        b32.ill_clr = 1'b1;
        xfer(1'b0, 32'h0000007F, 8'h5C, 64'h0, 3'd7, "ill_clr");
        b32.ill_clr = 1'b0;
        check("ill.clr_wins", 64'(b32.ill_count), 64'd0);
        xfer(1'b0, 32'h003100B3, 8'h5D, 64'h0, 3'd0, "legal_after_clr");
        check("ill.legal_no_inc", 64'(b32.ill_count), 64'd0);

        // Backpressure: three stalled cycles, then release and drain in order.
        idle();
        idx = 0;
        got = 0;
        for (int c = 0; c < 3; c++) begin
            b32.out_ready = 1'b0;
            b32.in_valid  = 1'b1;
            b32.in_inst   = bp_inst[idx];
            b32.in_tag    = 8'(8'h21 + idx);
            if (b32.in_ready) idx++;
            @(negedge clk);
        end
        check("bp.accepted", 64'(idx), 64'd2);
        check("bp.in_ready_low", 64'(b32.in_ready), 64'd0);
        check("bp.hold_valid", 64'(b32.out_valid), 64'd1);
        check("bp.hold_tag", 64'(b32.out_tag), 64'h21);
        check("bp.hold_imm", 64'(b32.out_imm), bp_imm[0]);
        for (int c = 0; c < 20 && got < 4; c++) begin
            b32.out_ready = 1'b1;
            if (idx < 4) begin
                b32.in_valid = 1'b1;
                b32.in_inst  = bp_inst[idx];
                b32.in_tag   = 8'(8'h21 + idx);
            end else begin
                b32.in_valid = 1'b0;
            end
            accept = b32.in_valid && b32.in_ready;
            if (b32.out_valid) begin
                check($sformatf("bp.tag%0d", got), 64'(b32.out_tag), 64'(8'(8'h21 + got)));
                check($sformatf("bp.imm%0d", got), 64'(b32.out_imm), bp_imm[got]);
                got++;
            end
            if (accept) idx++;
            @(negedge clk);
        end
        b32.in_valid = 1'b0;
        check("bp.drained", 64'(got), 64'd4);
        check("bp.no_dup", 64'(b32.out_valid), 64'd0);

        // 64-bit sign extension.
        xfer(1'b1, 32'hFFF00093, 8'h31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "x64.addi_m1");
        xfer(1'b1, 32'h80000017, 8'h32, 64'hFFFF_FFFF_8000_0000, 3'd4, "x64.auipc_neg");
        xfer(1'b1, 32'h123450B7, 8'h33, 64'h0000_0000_1234_5000, 3'd4, "x64.lui");
        xfer(1'b1, 32'hFE000EE3, 8'h34, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, "x64.beq_m4");

        // Saturation of the 4-bit counter on the 64-bit instance.
        idle();
        for (int c = 0; c < 17; c++) begin
            b64.in_valid = 1'b1;
            b64.in_inst  = 32'h0000007F;
            b64.in_tag   = 8'(c);
            @(negedge clk);
        end
        b64.in_valid = 1'b0;
        check("sat.count", 64'(b64.ill_count), 64'hF);
        b64.ill_clr = 1'b1;
        @(negedge clk);
        b64.ill_clr = 1'b0;
        check("sat.clr", 64'(b64.ill_count), 64'd0);

        // Asynchronous reset with both M and K full.
        idle();
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1; b32.in_inst = 32'h0000007F; b32.in_tag = 8'h41;
        @(negedge clk);
        b32.in_inst = 32'h123450B7; b32.in_tag = 8'h42;
        @(negedge clk);
        b32.in_valid = 1'b0;
        check("mrst.full_in_ready", 64'(b32.in_ready), 64'd0);
        check("mrst.full_valid", 64'(b32.out_valid), 64'd1);
        check("mrst.pre_count", 64'(b32.ill_count), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mrst.out_valid", 64'(b32.out_valid), 64'd0);
        check("mrst.in_ready", 64'(b32.in_ready), 64'd1);
        check("mrst.out_tag", 64'(b32.out_tag), 64'd0);
        check("mrst.ill_count", 64'(b32.ill_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst.still_empty", 64'(b32.out_valid), 64'd0);
        xfer(1'b0, 32'h001000EF, 8'h43, 64'h0000_0800, 3'd5, "mrst.first");

        idle();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
